// File: rtl/rca_pkg.sv
// Shared definitions for the two-stage split ripple-carry adder: default width,
// the stage-1 pipeline record and the overflow rule.
package rca_pkg;

    localparam int RCA_WIDTH = 16;
    localparam int RCA_LO    = RCA_WIDTH / 2;
    localparam int RCA_HI    = RCA_WIDTH - RCA_LO;

    // Stage-1 record: low-half result plus the operand bits still to be added.
    typedef struct packed {
        logic              valid;
        logic [RCA_LO-1:0] sum_lo;
        logic              carry;
        logic [RCA_HI-1:0] a_hi;
        logic [RCA_HI-1:0] b_hi;
    } stage_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/rca_pipe_adder_if.sv
// Operand/result valid-ready bus of the pipelined adder; master is the
// producer/consumer side, slave is the adder itself.
interface rca_pipe_adder_if #(parameter int WIDTH = rca_pkg::RCA_WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic [15:0]      op_count;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf, op_count
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, Ovf, op_count
    );

endinterface

// File: rtl/rca_half.sv
// Combinational W-bit ripple-carry adder; one instance per half of the word.
module rca_half #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[W];
    end

endmodule

// File: rtl/rca_pipe_adder.sv
// Two-stage pipelined adder: low half in stage 1, high half plus flags in
// stage 2, with valid/ready flow control and a completed-result counter.
module rca_pipe_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH
) (
    input logic              clk,
    input logic              rst,
    rca_pipe_adder_if.slave  bus
);

    localparam int LO = WIDTH / 2;

    if (WIDTH != RCA_WIDTH || (WIDTH % 2) != 0) begin : g_bad_width
        $error("rca_pipe_adder: WIDTH must be even and match rca_pkg::RCA_WIDTH");
    end

    stage_t           s1_q, s1_d;
    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [LO-1:0]    sum_lo, sum_hi;
    logic             c_lo, c_hi;
    logic             load_p2, acc_p1, out_hs, in_ready;

    rca_half #(.W(LO)) u_lo (
        .a    (bus.A[LO-1:0]),
        .b    (bus.B[LO-1:0]),
        .cin  (bus.Cin),
        .sum  (sum_lo),
        .cout (c_lo)
    );

    rca_half #(.W(LO)) u_hi (
        .a    (s1_q.a_hi),
        .b    (s1_q.b_hi),
        .cin  (s1_q.carry),
        .sum  (sum_hi),
        .cout (c_hi)
    );

    // Ready depends only on registered state and out_ready, never on in_valid.
    always_comb begin
        load_p2  = s1_q.valid && (!vld_p2_q || bus.out_ready);
        in_ready = !s1_q.valid || load_p2;
        acc_p1   = bus.in_valid && in_ready;
        out_hs   = vld_p2_q && bus.out_ready;
    end

    // stage 0 -> 1: low-half sum and carry, upper operand halves carried along
    always_comb begin
        s1_d = s1_q;
        if (acc_p1) begin
            s1_d.valid  = 1'b1;
            s1_d.sum_lo = sum_lo;
            s1_d.carry  = c_lo;
            s1_d.a_hi   = bus.A[WIDTH-1:LO];
            s1_d.b_hi   = bus.B[WIDTH-1:LO];
        end else if (load_p2) begin
            s1_d.valid  = 1'b0;
        end
    end

    // stage 1 -> 2: high-half sum completes the result; held while stalled
    always_comb begin
        vld_p2_d = vld_p2_q;
        s_d      = s_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (load_p2) begin
            vld_p2_d = 1'b1;
            s_d      = {sum_hi, s1_q.sum_lo};
            cout_d   = c_hi;
            ovf_d    = ovf_f(s1_q.a_hi[LO-1], s1_q.b_hi[LO-1], sum_hi[LO-1]);
        end else if (out_hs) begin
            vld_p2_d = 1'b0;
        end
        cnt_d = cnt_q + {15'd0, out_hs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q.valid <= 1'b0;
            vld_p2_q   <= 1'b0;
            s_q        <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= s1_d;
            vld_p2_q   <= vld_p2_d;
            s_q        <= s_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p2_q;
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.Ovf       = ovf_q;
    assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Bench for rca_pipe_adder: directed vector table, stall/reset sequences and
// random traffic scored against an arithmetic reference queue.
module tb_rca_pipe_adder;

    typedef struct {
        logic [16:0] res;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst;

    rca_pipe_adder_if #(.WIDTH(16)) bus ();

    rca_pipe_adder #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          ins    = 0;
    int          outs   = 0;
    logic [15:0] mcnt   = '0;
    exp_t        q[$];
    vec_t        tbl[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        exp_t e;
        int   sa;
        sa    = int'($signed(a)) + int'($signed(b)) + int'(cin);
        e.res = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.ovf = (sa > 32767) || (sa < -32768);
        return e;
    endfunction

    // Observe the cycle about to complete, update the scoreboard, move to next negedge.
    task automatic tick();
        bit   ih, oh;
        exp_t e;
        #1;
        ih = bus.in_valid && bus.in_ready;
        oh = bus.out_valid && bus.out_ready;
        if (rst) begin
            q.delete();
            mcnt = '0;
        end else begin
            if (bus.out_valid && q.size() > 0) begin
                e = q[0];
                chk("result_sum", {15'd0, bus.Cout, bus.S}, {15'd0, e.res});
                chk("result_ovf", {31'd0, bus.Ovf}, {31'd0, e.ovf});
            end
            if (oh) begin
                chk("out_expected", (q.size() > 0), 1);
                if (q.size() > 0) void'(q.pop_front());
                mcnt++;
                outs++;
            end
            if (ih) begin
                q.push_back(model(bus.A, bus.B, bus.Cin));
                ins++;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_beat();
        bus.A   = 16'($urandom);
        bus.B   = 16'($urandom);
        bus.Cin = 1'($urandom);
    endtask

    task automatic drain(input string name);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        chk(name, q.size(), 0);
    endtask

    initial begin
        exp_t e0;
        int   ib, ob, bubbles, need;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[4] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_op_count", {16'd0, bus.op_count}, 0);
        chk("rst_sum", {15'd0, bus.Cout, bus.S}, 0);
        chk("rst_ovf", {31'd0, bus.Ovf}, 0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);

        // Directed vectors, one beat at a time, with two-cycle latency.
        for (int i = 0; i < 8; i++) begin
            bus.in_valid  = 1'b1;
            bus.A         = tbl[i].a;
            bus.B         = tbl[i].b;
            bus.Cin       = tbl[i].cin;
            bus.out_ready = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk("latency_1cyc_not_valid", {31'd0, bus.out_valid}, 0);
            tick();
            chk("latency_2cyc_valid", {31'd0, bus.out_valid}, 1);
            chk("vec_S", {16'd0, bus.S}, {16'd0, tbl[i].s});
            chk("vec_Cout", {31'd0, bus.Cout}, {31'd0, tbl[i].cout});
            chk("vec_Ovf", {31'd0, bus.Ovf}, {31'd0, tbl[i].ovf});
            tick();
            chk("vec_op_count", {16'd0, bus.op_count}, {16'd0, mcnt});
            if (i == 0) chk("basic_op_count_one", {16'd0, bus.op_count}, 1);
        end

        // Back-pressure: third beat must wait until the consumer is ready.
        ob            = outs;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_beat();
        e0 = model(bus.A, bus.B, bus.Cin);
        tick();
        rand_beat();
        tick();
        rand_beat();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready_low", {31'd0, bus.in_ready}, 0);
            chk("bp_S_held", {15'd0, bus.Cout, bus.S}, {15'd0, e0.res});
            tick();
        end
        bus.out_ready = 1'b1;
        ib = ins;
        for (int k = 0; k < 10 && ins == ib; k++) tick();
        chk("bp_third_accepted", ins - ib, 1);
        drain("bp_drain_empty");
        chk("bp_three_out", outs - ob, 3);

        // Random valid/ready traffic.
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rand_beat();
            tick();
        end
        drain("mix_drain_empty");
        chk("mix_op_count", {16'd0, bus.op_count}, {16'd0, mcnt});

        // Reset with both stages full and handshakes pending.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_beat();
        tick();
        rand_beat();
        tick();
        #1;
        chk("full_in_ready_low", {31'd0, bus.in_ready}, 0);
        chk("full_out_valid", {31'd0, bus.out_valid}, 1);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("midrst_op_count", {16'd0, bus.op_count}, 0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("midrst_no_stale", {31'd0, bus.out_valid}, 0);
        end

        // Full-rate streaming, no bubbles.
        ob            = outs;
        bubbles       = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            rand_beat();
            #1;
            if (!bus.in_ready) bubbles++;
            if (k >= 2 && !bus.out_valid) bubbles++;
            tick();
        end
        chk("stream_bubbles", bubbles, 0);
        drain("stream_drain_empty");
        chk("stream_outs", outs - ob, 256);
        chk("stream_op_count", {16'd0, bus.op_count}, 256);

        // Run the counter up to its top value, then wrap it.
        need         = 16'hFFFF - int'(mcnt);
        ib           = ins;
        bus.in_valid = 1'b1;
        for (int k = 0; k < need; k++) begin
            rand_beat();
            tick();
        end
        chk("wrap_preload_accepted", ins - ib, need);
        drain("wrap_drain_empty");
        chk("wrap_at_max", {16'd0, bus.op_count}, 32'h0000FFFF);
        bus.in_valid = 1'b1;
        rand_beat();
        tick();
        drain("wrap_last_drain");
        chk("wrap_to_zero", {16'd0, bus.op_count}, 0);
        chk("wrap_model_count", {16'd0, bus.op_count}, {16'd0, mcnt});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rca_pipe_adder.md
RCA_PIPE_ADDER -- requirements
Module: rca_pipe_adder

Interface
REQ-001 Parameter: WIDTH, 16, operand/sum width; SHALL be even, with LO = WIDTH/2.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block accepts beat this cycle.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 Cin  input  1  carry in.
REQ-009 out_valid  output  1  result beat offered.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 S  output  WIDTH  sum.
REQ-012 Cout  output  1  carry out.
REQ-013 Ovf  output  1  two's-complement overflow of A+B+Cin.
REQ-014 op_count  output  16  completed output handshakes.

Function
REQ-015 An input handshake SHALL occur when in_valid && in_ready are both high at posedge clk; an output handshake SHALL occur when out_valid && out_ready are both high.
REQ-016 Stage 1 SHALL register the low-half sum A[LO-1:0]+B[LO-1:0]+Cin, its carry, and A/B upper halves.
REQ-017 Stage 2 SHALL register the upper-half sum using the stage-1 carry, producing S, Cout and Ovf.
REQ-018 Latency SHALL be exactly 2 cycles, input handshake to out_valid, when out_ready is held high.
REQ-019 Stage 2 SHALL load when s1_valid && (!out_valid || out_ready).
REQ-020 in_ready SHALL equal !s1_valid || stage-2 load; it SHALL be combinational and SHALL NOT depend on in_valid.
REQ-021 With out_ready held high, throughput SHALL be one beat per cycle, with no bubbles.
REQ-022 While out_valid && !out_ready, S, Cout and Ovf SHALL hold stable, and no accepted beat SHALL be lost or duplicated.
REQ-023 Stalls: after 2 stalled beats (both stages full), in_ready SHALL be low until out_ready rises.
REQ-024 Simultaneous output handshake and stage-1 advance in one cycle SHALL transfer stage 1 to stage 2 with no bubble.
REQ-025 {Cout,S} SHALL equal A+B+Cin modulo 2^(WIDTH+1) for every beat.
REQ-026 Ovf SHALL be (A[msb]==B[msb]) && (S[msb]!=A[msb]).
REQ-027 op_count SHALL increment by 1 per output handshake and wrap from 16'hFFFF to 0.
REQ-028 Beats SHALL leave in acceptance order.

Reset
REQ-029 While rst is high at posedge clk, the following SHALL be cleared: s1_valid, out_valid, S, Cout, Ovf and op_count (all to 0).
REQ-030 In-flight beats SHALL be discarded by reset.
REQ-031 in_ready SHALL be 1 in the cycle after reset is released.
REQ-032 Reset asserted mid-stream SHALL take priority over any handshake in the same cycle.

Structure
REQ-033 The WIDTH default and the pipeline-stage record typedef (valid, partial sum, carry, upper operands) SHALL reside in shared package rca_pkg.
REQ-034 Each half SHALL be built from one sub-module rca_half, a LO-bit ripple-carry adder (combinational), instantiated twice.
REQ-035 Handshake logic SHALL contain no latches and no combinational path from in_valid to in_ready.

Verification
REQ-036 Basic: A=16'h00FF, B=16'h0001, Cin=0, out_ready=1 -> two cycles later S=16'h0100, Cout=0, Ovf=0, op_count=1.
REQ-037 Carry and overflow: beat 1 A=16'hFFFF, B=16'h0001, Cin=1 -> S=16'h0001, Cout=1, Ovf=0; beat 2 A=16'h7FFF, B=16'h0001, Cin=0 -> S=16'h8000, Cout=0, Ovf=1.
REQ-038 Back-pressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0, S held on beat 1; then out_ready=1 -> beats drain in order, third accepted, no loss.
REQ-039 Streaming: 256 random beats with in_valid and out_ready both 1 -> one result per cycle, each matching A+B+Cin, op_count=256.
REQ-040 Reset mid-stream: assert rst with both stages full -> next cycle out_valid=0, op_count=0, in_ready=1; no stale beat emerges.
REQ-041 Wrap: preload op_count to 16'hFFFF via 65535 handshakes, then one more handshake -> op_count=0.
